// File: rtl/float2fix_arb.sv
`default_nettype none
// ============================================================================
// Module   : float2fix_arb
// Purpose  : Round-robin scheduler sharing one fixed-latency float2fix
//            datapath between NREQ requesters, with result routing and
//            protocol-mismatch flags.
// Revision : 1.0 - initial release
// ============================================================================
module float2fix_arb #(
    parameter int NREQ  = 4,
    parameter int LAT   = 3,
    parameter int LANES = 8,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NREQ-1:0]            cfg_en,
    input  logic                       err_clr,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*LANES*DW-1:0]   req_data,
    output logic                       src_valid,
    output logic [LANES*DW-1:0]        src_data,
    input  logic                       dst_valid,
    input  logic [LANES*DW-1:0]        dst_data,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [LANES*DW-1:0]        rsp_data,
    output logic                       busy,
    output logic                       err_unexpected,
    output logic                       err_missing
);

    localparam int c_vec_w = LANES * DW;
    localparam int c_id_w  = $clog2(NREQ);

    logic [NREQ-1:0]      w_elig;
    logic [NREQ-1:0]      w_grant;
    logic [c_id_w-1:0]    w_gnt_id;
    logic [c_vec_w-1:0]   w_gnt_data;
    logic                 w_found;
    logic                 w_accept;
    int                   w_idx;

    logic [c_id_w-1:0]    r_ptr;
    logic                 r_src_valid;
    logic [c_vec_w-1:0]   r_src_data;
    logic [c_id_w-1:0]    r_src_id;

    logic [LAT-1:0]       r_tag_vld;
    logic [c_id_w-1:0]    r_tag_id [LAT];
    logic                 w_tout_vld;
    logic [c_id_w-1:0]    w_tout_id;
    logic                 w_ret;
    logic [NREQ-1:0]      w_rsp_onehot;

    logic [NREQ-1:0]      r_rsp_valid;
    logic [c_vec_w-1:0]   r_rsp_data;
    logic                 r_err_unexpected;
    logic                 r_err_missing;

    assign w_elig = req_valid & cfg_en;

    // Scan from the round-robin pointer, wrapping, and take the first eligible.
    always_comb begin
        w_grant    = '0;
        w_gnt_id   = '0;
        w_gnt_data = '0;
        w_found    = 1'b0;
        w_idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && w_elig[w_idx]) begin
                w_found         = 1'b1;
                w_grant[w_idx]  = 1'b1;
                w_gnt_id        = c_id_w'(w_idx);
                w_gnt_data      = req_data[w_idx*c_vec_w +: c_vec_w];
            end
        end
    end

    assign req_ready = w_grant;
    assign w_accept  = |(req_valid & w_grant);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr       <= '0;
            r_src_valid <= 1'b0;
            r_src_data  <= '0;
            r_src_id    <= '0;
        end else begin
            r_src_valid <= w_accept;
            if (w_accept) begin
                r_src_data <= w_gnt_data;
                r_src_id   <= w_gnt_id;
                r_ptr      <= (w_gnt_id == c_id_w'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
            end
        end
    end

    // Tag pipe: the last stage lines up with the dst_valid of the same issue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tag_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_vld[0] <= r_src_valid;
            r_tag_id[0]  <= r_src_id;
            for (int i = 1; i < LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    assign w_tout_vld   = r_tag_vld[LAT-1];
    assign w_tout_id    = r_tag_id[LAT-1];
    assign w_ret        = dst_valid & w_tout_vld;
    assign w_rsp_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_tout_id;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rsp_valid      <= '0;
            r_rsp_data       <= '0;
            r_err_unexpected <= 1'b0;
            r_err_missing    <= 1'b0;
        end else begin
            r_rsp_valid <= w_ret ? w_rsp_onehot : '0;
            if (w_ret) begin
                r_rsp_data <= dst_data;
            end
            // A new error in the clearing cycle wins over the clear.
            r_err_unexpected <= (r_err_unexpected & ~err_clr) | (dst_valid & ~w_tout_vld);
            r_err_missing    <= (r_err_missing & ~err_clr) | (w_tout_vld & ~dst_valid);
        end
    end

    assign src_valid      = r_src_valid;
    assign src_data       = r_src_data;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign busy           = r_src_valid | (|r_tag_vld);
    assign err_unexpected = r_err_unexpected;
    assign err_missing    = r_err_missing;

endmodule
`default_nettype wire

// File: tb/tb_float2fix_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_float2fix_arb
// Purpose  : Self-checking bench for float2fix_arb with a behavioural
//            scheduler/datapath reference model and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_float2fix_arb;

    localparam int c_nreq  = 4;
    localparam int c_lat   = 3;
    localparam int c_lanes = 8;
    localparam int c_dw    = 32;
    localparam int c_vw    = c_lanes * c_dw;
    localparam int c_maxc  = 1024;

    logic                        clk = 1'b0;
    logic                        rstn = 1'b1;
    logic [c_nreq-1:0]           cfg_en;
    logic                        err_clr;
    logic [c_nreq-1:0]           req_valid;
    logic [c_nreq-1:0]           req_ready;
    logic [c_nreq*c_vw-1:0]      req_data;
    logic                        src_valid;
    logic [c_vw-1:0]             src_data;
    logic                        dst_valid;
    logic [c_vw-1:0]             dst_data;
    logic [c_nreq-1:0]           rsp_valid;
    logic [c_vw-1:0]             rsp_data;
    logic                        busy;
    logic                        err_unexpected;
    logic                        err_missing;

    float2fix_arb #(.NREQ(c_nreq), .LAT(c_lat), .LANES(c_lanes), .DW(c_dw)) u_dut (
        .clk            (clk),
        .rstn           (rstn),
        .cfg_en         (cfg_en),
        .err_clr        (err_clr),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .dst_valid      (dst_valid),
        .dst_data       (dst_data),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .busy           (busy),
        .err_unexpected (err_unexpected),
        .err_missing    (err_missing)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: accepts per cycle, expected responses per cycle, observed src stream.
    bit              acc_v  [c_maxc];
    int              acc_id [c_maxc];
    logic [c_vw-1:0] acc_d  [c_maxc];
    bit              er_v   [c_maxc];
    int              er_id  [c_maxc];
    logic [c_vw-1:0] er_d   [c_maxc];
    bit              dp_v   [c_maxc];
    logic [c_vw-1:0] dp_d   [c_maxc];
    int              mptr;
    bit              ef_u, ef_m;
    bit              fixed_data;

    task automatic check_eq(input string tag, input logic [c_vw-1:0] got, input logic [c_vw-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Stand-in for the float2fix datapath transform.
    function automatic logic [c_vw-1:0] dp_f(input logic [c_vw-1:0] x);
        logic [c_vw-1:0] y;
        for (int k = 0; k < c_lanes; k++) begin
            y[k*c_dw +: c_dw] = ~x[k*c_dw +: c_dw] + 32'(k);
        end
        return y;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < c_maxc; i++) begin
            acc_v[i] = 1'b0; acc_id[i] = 0; acc_d[i] = '0;
            er_v[i]  = 1'b0; er_id[i]  = 0; er_d[i]  = '0;
            dp_v[i]  = 1'b0; dp_d[i]   = '0;
        end
        mptr = 0; ef_u = 1'b0; ef_m = 1'b0; cyc = 16;
    endtask

    task automatic do_reset();
        rstn = 1'b0; req_valid = '0; err_clr = 1'b0; dst_valid = 1'b0;
        #1;
        check_eq("rst_src_valid", src_valid, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err_unexpected", err_unexpected, 0);
        check_eq("rst_err_missing", err_missing, 0);
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [c_nreq-1:0] rv, input logic [c_nreq-1:0] en,
                        input bit clr, input bit drop, input bit spur);
        bit              due, dv, exp_busy, un, mn;
        logic [c_nreq-1:0] exp_rdy;
        int              g, idx;
        // Registered outputs for this cycle.
        check_eq("src_valid", src_valid, acc_v[cyc-1]);
        if (acc_v[cyc-1]) check_eq("src_data", src_data, acc_d[cyc-1]);
        check_eq("rsp_valid", rsp_valid, er_v[cyc] ? (4'b0001 << er_id[cyc]) : 4'b0000);
        if (er_v[cyc]) check_eq("rsp_data", rsp_data, er_d[cyc]);
        check_eq("err_unexpected", err_unexpected, ef_u);
        check_eq("err_missing", err_missing, ef_m);
        exp_busy = 1'b0;
        for (int i = 1; i <= c_lat + 1; i++) exp_busy |= acc_v[cyc-i];
        check_eq("busy", busy, exp_busy);
        // Datapath model: fixed latency from the observed src stream.
        dp_v[cyc] = src_valid; dp_d[cyc] = src_data;
        dv = (dp_v[cyc-c_lat] && !drop) || spur;
        dst_valid = dv;
        if (dp_v[cyc-c_lat]) dst_data = dp_f(dp_d[cyc-c_lat]);
        else for (int k = 0; k < c_lanes; k++) dst_data[k*c_dw +: c_dw] = $urandom;
        // Reference: issue accepted at cyc-1-LAT owns this cycle's dst slot.
        due = acc_v[cyc-1-c_lat];
        if (due && dv) begin
            er_v[cyc+1]  = 1'b1;
            er_id[cyc+1] = acc_id[cyc-1-c_lat];
            er_d[cyc+1]  = dp_f(acc_d[cyc-1-c_lat]);
        end
        un = (ef_u && !clr) || (dv && !due);
        mn = (ef_m && !clr) || (due && !dv);
        // Requests.
        req_valid = rv; cfg_en = en; err_clr = clr;
        for (int k = 0; k < c_nreq * c_lanes; k++)
            req_data[k*c_dw +: c_dw] = (fixed_data && k < c_lanes) ? 32'h3F80_0000 : $urandom;
        #1;
        exp_rdy = '0; g = -1;
        for (int k = 0; k < c_nreq; k++) begin
            idx = (mptr + k) % c_nreq;
            if (g < 0 && rv[idx] && en[idx]) g = idx;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_eq("req_ready", req_ready, exp_rdy);
        acc_v[cyc] = (g >= 0);
        if (g >= 0) begin
            acc_id[cyc] = g;
            acc_d[cyc]  = req_data[g*c_vw +: c_vw];
            mptr        = (g + 1) % c_nreq;
        end
        @(posedge clk);
        cyc++; ef_u = un; ef_m = mn;
        #1;
    endtask

    initial begin
        cfg_en = '1; err_clr = 1'b0; req_valid = '0; req_data = '0;
        dst_valid = 1'b0; dst_data = '0; fixed_data = 1'b0;
        #3;
        do_reset();
        // Single issue of 1.0 lanes from requester 0.
        fixed_data = 1'b1;
        step(4'b0001, 4'hF, 0, 0, 0);
        fixed_data = 1'b0;
        repeat (c_lat + 3) step(4'b0000, 4'hF, 0, 0, 0);
        // Missing dst_valid, then spurious dst_valid, then clear.
        step(4'b0001, 4'hF, 0, 0, 0);
        for (int i = 1; i <= c_lat + 1; i++) step(4'b0000, 4'hF, 0, (i == c_lat + 1), 0);
        step(4'b0000, 4'hF, 0, 0, 0);
        step(4'b0000, 4'hF, 0, 0, 1);
        step(4'b0000, 4'hF, 0, 0, 0);
        step(4'b0000, 4'hF, 1, 0, 0);
        step(4'b0000, 4'hF, 0, 0, 0);
        // Clear and new error in the same cycle: flag stays set.
        step(4'b0000, 4'hF, 1, 0, 1);
        step(4'b0000, 4'hF, 1, 0, 0);
        step(4'b0000, 4'hF, 0, 0, 0);
        // Mid-stream reset with an error flag set and work in flight.
        step(4'b0000, 4'hF, 0, 0, 1);
        repeat (4) step(4'b1111, 4'hF, 0, 0, 0);
        do_reset();
        repeat (c_lat + 4) step(4'b0000, 4'hF, 0, 0, 0);
        // Round robin, all requesting.
        repeat (5) step(4'b1111, 4'hF, 0, 0, 0);
        repeat (c_lat + 3) step(4'b0000, 4'hF, 0, 0, 0);
        // Requester 2 disabled.
        repeat (4) step(4'b1111, 4'b1011, 0, 0, 0);
        repeat (c_lat + 3) step(4'b0000, 4'hF, 0, 0, 0);
        // Back-to-back from requester 1 alone.
        repeat (20) step(4'b0010, 4'hF, 0, 0, 0);
        repeat (c_lat + 3) step(4'b0000, 4'hF, 0, 0, 0);
        // Randomized traffic with occasional faults and clears.
        for (int n = 0; n < 300; n++) begin
            logic [c_nreq-1:0] rv, en;
            bit clr, drop, spur;
            rv   = c_nreq'($urandom);
            en   = ($urandom_range(0, 3) == 0) ? c_nreq'($urandom) : 4'hF;
            clr  = ($urandom_range(0, 15) == 0);
            drop = ($urandom_range(0, 19) == 0);
            spur = !acc_v[cyc-1-c_lat] && ($urandom_range(0, 19) == 0);
            step(rv, en, clr, drop, spur);
        end
        repeat (c_lat + 3) step(4'b0000, 4'hF, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
